// File: rtl/gray_to_binary_pipe.sv
// Two-stage registered Gray-to-binary decoder with a valid/ready handshake.
// Flags wraps and sequence steps relative to the previously decoded word.
module gray_to_binary_pipe #(
  parameter int WIDTH      = 4,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary_out,
  output logic             out_wrap,
  output logic             out_step_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic             en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_gray;
  logic [WIDTH-1:0] prev_bin;
  logic             first_flag;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] prev_inc;
  logic             wrap_next;
  logic             step_err_next;

  // The whole pipe advances together; a stalled output freezes both stages.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = s1_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ s1_gray[i];
    end
  end

  always_comb begin
    prev_inc      = prev_bin + 1'b1;
    wrap_next     = 1'b0;
    step_err_next = 1'b0;
    if (!first_flag) begin
      wrap_next     = (prev_bin == MAX_VAL) && (dec_bin == '0);
      step_err_next = (dec_bin != prev_inc) && !(ALLOW_HOLD && (dec_bin == prev_bin));
    end
  end

  // Bubbles leave the sequence history untouched and clear the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_gray      <= '0;
      out_valid    <= 1'b0;
      binary_out   <= '0;
      out_wrap     <= 1'b0;
      out_step_err <= 1'b0;
      prev_bin     <= '0;
      first_flag   <= 1'b1;
    end else if (en) begin
      s1_gray   <= gray_in;
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        binary_out   <= dec_bin;
        out_wrap     <= wrap_next;
        out_step_err <= step_err_next;
        prev_bin     <= dec_bin;
        first_flag   <= 1'b0;
      end else begin
        out_wrap     <= 1'b0;
        out_step_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Directed self-checking bench; runs a hold-tolerant and a hold-strict
// instance side by side on identical stimulus.
module tb_gray_to_binary_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_wrap,  out_step_err;
  logic [3:0] binary_out;
  logic       in_ready_nh, out_valid_nh, out_wrap_nh, out_step_err_nh;
  logic [3:0] binary_out_nh;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_to_binary_pipe #(.WIDTH(4), .ALLOW_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
    .binary_out(binary_out), .out_wrap(out_wrap), .out_step_err(out_step_err)
  );

  gray_to_binary_pipe #(.WIDTH(4), .ALLOW_HOLD(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nh),
    .gray_in(gray_in), .out_valid(out_valid_nh), .out_ready(out_ready),
    .binary_out(binary_out_nh), .out_wrap(out_wrap_nh), .out_step_err(out_step_err_nh)
  );

  // Gray codes of binary 0..15, then 0 again to force a wrap.
  logic [3:0] gray_tab [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] bin_tab  [0:16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] g, input logic ordy);
    in_valid  = v;
    gray_in   = g;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 4'h5, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_valid_nh !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got %b/%b want 0", out_valid, out_valid_nh);
    end
    vectors++;
    if (out_wrap !== 1'b0 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got wrap=%b err=%b want 0/0", out_wrap, out_step_err);
    end
    vectors++;
    if (binary_out !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_binary_out got %h want 0", binary_out);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  // Word k accepted on iteration k is visible after the following edge.
  task automatic test_sweep();
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      if (k <= 16) applyStimulus(1'b1, gray_tab[k], 1'b1);
      else         applyStimulus(1'b0, 4'h0, 1'b1);
      tick();
      if (k >= 1) begin
        vectors++;
        if (out_valid !== 1'b1 || binary_out !== bin_tab[k-1]) begin
          miscompares++;
          $display("[TB] FAIL sweep_data[%0d] got v=%b bin=%h want v=1 bin=%h",
                   k-1, out_valid, binary_out, bin_tab[k-1]);
        end
        vectors++;
        if (out_wrap !== (k == 17) || out_step_err !== 1'b0 || out_step_err_nh !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL sweep_flags[%0d] got wrap=%b err=%b err_nh=%b want wrap=%b err=0",
                   k-1, out_wrap, out_step_err, out_step_err_nh, (k == 17));
        end
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_wrap !== 1'b0 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_bubble got v=%b wrap=%b err=%b want 0/0/0",
               out_valid, out_wrap, out_step_err);
    end
  endtask

  task automatic test_back_pressure();
    int delivered;
    delivered = 0;
    do_reset();
    applyStimulus(1'b1, 4'h4, 1'b1);
    tick();
    applyStimulus(1'b1, 4'hC, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd7 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_first got v=%b bin=%h err=%b want 1/7/0", out_valid, binary_out, out_step_err);
    end
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 4'hD, 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_in_ready[%0d] got %b want 0", s, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || binary_out !== 4'd7 || out_step_err !== 1'b0 || out_wrap !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b bin=%h err=%b wrap=%b want 1/7/0/0",
                 s, out_valid, binary_out, out_step_err, out_wrap);
      end
    end
    applyStimulus(1'b1, 4'hD, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd8 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_second got v=%b bin=%h err=%b want 1/8/0", out_valid, binary_out, out_step_err);
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd9 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_third got v=%b bin=%h err=%b want 1/9/0", out_valid, binary_out, out_step_err);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid === 1'b1) delivered++;
    end
    vectors++;
    if (delivered != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_duplicate got %0d extra words want 0", delivered);
    end
  endtask

  task automatic test_skip_error();
    do_reset();
    applyStimulus(1'b1, 4'h2, 1'b1);
    tick();
    applyStimulus(1'b1, 4'h7, 1'b1);
    tick();
    vectors++;
    if (binary_out !== 4'd3 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL skip_first got bin=%h err=%b want 3/0", binary_out, out_step_err);
    end
    applyStimulus(1'b1, 4'h5, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd5 || out_step_err !== 1'b1 || out_step_err_nh !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL skip_err got v=%b bin=%h err=%b err_nh=%b want 1/5/1/1",
               out_valid, binary_out, out_step_err, out_step_err_nh);
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (binary_out !== 4'd6 || out_step_err !== 1'b0 || out_wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL skip_recover got bin=%h err=%b wrap=%b want 6/0/0", binary_out, out_step_err, out_wrap);
    end
  endtask

  task automatic test_hold();
    do_reset();
    applyStimulus(1'b1, 4'h6, 1'b1);
    tick();
    tick();
    vectors++;
    if (binary_out !== 4'd4 || out_step_err !== 1'b0 || out_step_err_nh !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_first got bin=%h err=%b err_nh=%b want 4/0/0",
               binary_out, out_step_err, out_step_err_nh);
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd4 || out_step_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_allowed got v=%b bin=%h err=%b want 1/4/0", out_valid, binary_out, out_step_err);
    end
    vectors++;
    if (out_valid_nh !== 1'b1 || binary_out_nh !== 4'd4 || out_step_err_nh !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_strict got v=%b bin=%h err=%b want 1/4/1",
               out_valid_nh, binary_out_nh, out_step_err_nh);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    applyStimulus(1'b1, 4'hD, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_flush got v=%b bin=%h want v=0", out_valid, binary_out);
    end
    applyStimulus(1'b1, 4'h2, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_stale got v=%b bin=%h want v=0", out_valid, binary_out);
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || binary_out !== 4'd3 || out_step_err !== 1'b0 || out_wrap !== 1'b0
        || out_step_err_nh !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_next got v=%b bin=%h err=%b wrap=%b want 1/3/0/0",
               out_valid, binary_out, out_step_err, out_wrap);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b1);
    test_reset();
    test_sweep();
    test_back_pressure();
    test_skip_error();
    test_hold();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
